// File: rtl/operand_seq_pkg.sv
// Shared types and helpers for the operand line sequencer.
package operand_seq_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} seq_state_e;

  localparam int LINE_BITS   = 512;
  localparam int STATUS_BITS = 32;

  // Pair `index` ends up in the low 2*data_len bits: a below, b above.
  function automatic logic [LINE_BITS-1:0] pair_extract(input logic [LINE_BITS-1:0] line,
                                                        input int index,
                                                        input int data_len);
    return line >> (2 * index * data_len);
  endfunction

endpackage

// File: rtl/operand_seq_valid_pipe.sv
// LATENCY-deep {valid, tag} shift register that tracks operands in flight
// through the arithmetic unit; reset and flush drop every pending entry.
module operand_seq_valid_pipe #(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             head_valid,
  output logic [TAG_W-1:0] head_tag
);

  logic [LATENCY-1:0] vld_p;
  logic [TAG_W-1:0]   tag_p [LATENCY];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Tags are qualified by vld_p, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_p[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) tag_p[i] <= tag_p[i-1];
  end

  assign head_valid = vld_p[LATENCY-1];
  assign head_tag   = tag_p[LATENCY-1];

endmodule

// File: rtl/operand_line_sequencer.sv
// Streams the operand pairs of one cache line through a fixed-latency unit and
// packs the results into a line. Optional status word: OPERAND_SEQ_STATUS_EN.
module operand_line_sequencer
  import operand_seq_pkg::*;
#(
  parameter int DATA_LEN  = 32,
  parameter int NUM_PAIRS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LINE_BITS-1:0] in_line,
  input  logic [7:0]           in_count,
  output logic                 op_valid,
  output logic [DATA_LEN-1:0]  op_a,
  output logic [DATA_LEN-1:0]  op_b,
  input  logic [DATA_LEN-1:0]  op_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LINE_BITS-1:0] out_line,
  output logic                 busy
);

  localparam int TAG_W  = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int PAIR_W = 2 * DATA_LEN;
  localparam logic [7:0] MAX_N = 8'(NUM_PAIRS);
`ifdef OPERAND_SEQ_STATUS_EN
  localparam int OFS = STATUS_BITS;
`else
  localparam int OFS = 0;
`endif

  seq_state_e           state;
  logic [LINE_BITS-1:0] line_reg;
  logic [LINE_BITS-1:0] results;
  logic [7:0]           n;
  logic [7:0]           n_next;
  logic [7:0]           n_m1;
  logic [7:0]           idx;
  logic [TAG_W-1:0]     op_tag;
  logic [PAIR_W-1:0]    pair;
  logic                 head_valid;
  logic [TAG_W-1:0]     head_tag;
  int                   slot_lo;
`ifdef OPERAND_SEQ_STATUS_EN
  logic [15:0]          line_seq;
`endif

  assign in_ready = (state == IDLE) && !reset;
  assign busy     = (state != IDLE);
  assign out_line = results;
  assign n_next   = (in_count > MAX_N) ? MAX_N : in_count;
  assign n_m1     = n - 8'd1;

  // Pair 0 comes straight off in_line so op_valid rises the cycle after accept.
  always_comb begin
    pair    = '0;
    slot_lo = int'(head_tag) * DATA_LEN + OFS;
    if (state == IDLE) pair = PAIR_W'(pair_extract(in_line, 0, DATA_LEN));
    else               pair = PAIR_W'(pair_extract(line_reg, int'(idx), DATA_LEN));
  end

  operand_seq_valid_pipe #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W)
  ) u_valid_pipe (
    .clk        (clk),
    .reset      (reset),
    .flush      (in_valid && in_ready),
    .in_valid   (op_valid),
    .in_tag     (op_tag),
    .head_valid (head_valid),
    .head_tag   (head_tag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      out_valid <= 1'b0;
      results   <= '0;
`ifdef OPERAND_SEQ_STATUS_EN
      line_seq  <= 16'd0;
`endif
    end else begin
      if (head_valid) results[slot_lo +: DATA_LEN] <= op_result;
      case (state)
        IDLE: begin
          if (in_valid) begin
            line_reg <= in_line;
            n        <= n_next;
            results  <= '0;
`ifdef OPERAND_SEQ_STATUS_EN
            results[STATUS_BITS-1:0] <= {line_seq, 8'h00, n_next};
`endif
            if (n_next == 8'd0) begin
              out_valid <= 1'b1;
              state     <= OUTPUT;
            end else begin
              op_valid <= 1'b1;
              op_a     <= pair[DATA_LEN-1:0];
              op_b     <= pair[PAIR_W-1:DATA_LEN];
              op_tag   <= '0;
              idx      <= 8'd1;
              state    <= (n_next == 8'd1) ? DRAIN : ISSUE;
            end
          end
        end
        ISSUE: begin
          op_valid <= 1'b1;
          op_a     <= pair[DATA_LEN-1:0];
          op_b     <= pair[PAIR_W-1:DATA_LEN];
          op_tag   <= idx[TAG_W-1:0];
          idx      <= idx + 8'd1;
          if (idx == n_m1) state <= DRAIN;
        end
        DRAIN: begin
          op_valid <= 1'b0;
          // Tags retire in order, so the last tag at the head is the final write.
          if (head_valid && head_tag == n_m1[TAG_W-1:0]) begin
            out_valid <= 1'b1;
            state     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
`ifdef OPERAND_SEQ_STATUS_EN
            line_seq  <= line_seq + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_line_sequencer.sv
// Bench for operand_line_sequencer with a latency-matched multiplier model;
// expectations follow OPERAND_SEQ_STATUS_EN when it is defined.
module tb_operand_line_sequencer;

  localparam int DL  = 32;
  localparam int NP  = 8;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [511:0]   in_line;
  logic [7:0]     in_count;
  logic           op_valid;
  logic [DL-1:0]  op_a;
  logic [DL-1:0]  op_b;
  logic [DL-1:0]  op_result;
  logic           out_valid;
  logic           out_ready;
  logic [511:0]   out_line;
  logic           busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int seq      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  operand_line_sequencer #(.DATA_LEN(DL), .NUM_PAIRS(NP), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_line   (in_line),
    .in_count  (in_count),
    .op_valid  (op_valid),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_result (op_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_line  (out_line),
    .busy      (busy)
  );

  // Multiplier stand-in; emits junk whenever nothing valid was presented.
  logic [DL-1:0] mul_p [LAT];
  always @(posedge clk) begin
    mul_p[0] <= op_valid ? op_a * op_b : $urandom;
    for (int i = 1; i < LAT; i++) mul_p[i] <= mul_p[i-1];
  end
  assign op_result = mul_p[LAT-1];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] model_line(input logic [511:0] line, input int n, input int s);
    logic [511:0] r;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [15:0]  s16;
    int           ofs;
    r   = '0;
    ofs = 0;
    s16 = 16'(s);
`ifdef OPERAND_SEQ_STATUS_EN
    ofs = 32;
    r[31:0] = {s16, 8'h00, 8'(n)};
`endif
    for (int k = 0; k < n; k++) begin
      a = line[64*k +: 32];
      b = line[64*k + 32 +: 32];
      r[ofs + 32*k +: 32] = a * b;
    end
    return r;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_in_ready"}, 512'(in_ready), 512'(1));
  endtask

  // One full line: accept, watch the issue stream, check result line, then handshake.
  task automatic run_line(input string tag, input logic [511:0] line, input int cnt, input int stall);
    int n, t_acc, guard, ovc, lat;
    bit seq_ok, hold_ok;
    logic [511:0] exp, held;
    n   = (cnt > NP) ? NP : cnt;
    exp = model_line(line, n, seq);
    lat = (n == 0) ? 0 : n + LAT;
    wait_ready(tag);
    out_ready = (stall == 0);
    in_line   = line;
    in_count  = 8'(cnt);
    in_valid  = 1'b1;
    @(negedge clk);
    t_acc    = cyc;
    in_valid = 1'b0;
    in_line  = rand_line();
    ovc = 0; guard = 0; seq_ok = 1'b1;
    while (!out_valid && guard < 200) begin
      if (op_valid) begin
        if (ovc >= n || cyc - t_acc != ovc || {op_b, op_a} !== line[64*ovc +: 64]) seq_ok = 1'b0;
        ovc++;
      end
      @(negedge clk);
      guard++;
    end
    check({tag, "_out_valid"}, 512'(out_valid), 512'(1));
    check({tag, "_latency"}, 512'(cyc - t_acc), 512'(lat));
    check({tag, "_op_count"}, 512'(ovc), 512'(n));
    check({tag, "_op_stream"}, 512'(seq_ok), 512'(1));
    check({tag, "_out_line"}, out_line, exp);
    held = out_line;
    hold_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (out_line !== held || in_ready !== 1'b0 || out_valid !== 1'b1) hold_ok = 1'b0;
    end
    if (stall > 0) check({tag, "_hold"}, 512'(hold_ok), 512'(1));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    seq++;
    check({tag, "_after_hs"}, 512'({out_valid, in_ready, busy}), 512'(3'b010));
  endtask

  initial begin
    logic [511:0] l;
    reset = 1'b1; in_valid = 1'b0; in_line = '0; in_count = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready, op_valid, op_a, op_b, out_valid, busy, out_line},
          '0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 512'({in_ready, busy}), 512'(2'b10));

    for (int k = 0; k < 8; k++) begin
      l[64*k +: 32]      = 32'(k + 1);
      l[64*k + 32 +: 32] = 32'd3;
    end
    run_line("mul8", l, 8, 0);
    run_line("empty", rand_line(), 0, 2);
    run_line("clamp20", rand_line(), 20, 0);
    run_line("stall10", rand_line(), 5, 10);

    // Reset during the 4th issue cycle, then a short clean line.
    wait_ready("rst_mid");
    in_line = rand_line(); in_count = 8'd8; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_issuing", 512'(op_valid), 512'(1));
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {in_ready, op_valid, op_a, op_b, out_valid, busy, out_line}, '0);
    reset = 1'b0;
    seq = 0;
    l = '0;
    l[31:0] = 32'd5; l[63:32] = 32'd7; l[95:64] = 32'd6; l[127:96] = 32'd6;
    run_line("post_rst", l, 2, 0);

    run_line("stat1", rand_line(), 1, 0);
    run_line("stat2", rand_line(), 2, 1);
    run_line("stat3", rand_line(), 3, 0);

    for (int i = 0; i < 6; i++)
      run_line("rand", rand_line(), int'($urandom_range(0, 12)), int'($urandom_range(0, 3)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
